// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator with a PC-relative target.
// One registered output stage plus a one-entry skid buffer, with a valid/ready handshake.
// The decoder is a combinational sub-module, so imm and target are formed on the input side.

// Combinational decode: format select, sign-extension and pc + imm
module imm_gen_dec #(
  parameter int REG_WIDTH     = 32,
  parameter int IMM_SEL_WIDTH = 3
) (
  input  logic [31:0]              inst,
  input  logic [IMM_SEL_WIDTH-1:0] sel,
  input  logic [REG_WIDTH-1:0]     pc,
  output logic [REG_WIDTH-1:0]     imm,
  output logic [REG_WIDTH-1:0]     tgt,
  output logic                     illegal
);
  localparam logic [2:0] FMT_I = 3'd0, FMT_S = 3'd1, FMT_B = 3'd2,
                         FMT_U = 3'd3, FMT_J = 3'd4;
  localparam logic [IMM_SEL_WIDTH-1:0] SEL_AUTO = IMM_SEL_WIDTH'(5);
  localparam logic [IMM_SEL_WIDTH-1:0] SEL_MAXF = IMM_SEL_WIDTH'(4);

  logic [2:0]  fmt;
  logic [31:0] imm32;

  // Pick the format (explicit or from the opcode) and flag undecodable cases
  always_comb begin
    fmt     = FMT_I;
    illegal = 1'b0;
    if (sel == SEL_AUTO) begin
      unique case (inst[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
        // addiw and friends exist only on RV64
        7'b0011011: if (REG_WIDTH == 64) fmt = FMT_I; else illegal = 1'b1;
        7'b0100011:             fmt = FMT_S;
        7'b1100011:             fmt = FMT_B;
        7'b0110111, 7'b0010111: fmt = FMT_U;
        7'b1101111:             fmt = FMT_J;
        default:                illegal = 1'b1;
      endcase
    end else if (sel > SEL_MAXF) begin
      illegal = 1'b1;
    end else begin
      fmt = 3'(sel);
    end
  end

  // Assemble the 32-bit immediate, then sign-extend to XLEN; target wraps modulo 2^XLEN
  always_comb begin
    unique case (fmt)
      FMT_S:   imm32 = {{21{inst[31]}}, inst[30:25], inst[11:7]};
      FMT_B:   imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = {{21{inst[31]}}, inst[30:20]};
    endcase
    if (illegal) imm32 = '0;
    imm = REG_WIDTH'($signed(imm32));
    tgt = pc + imm;
  end
endmodule

module imm_gen_pipe #(
  parameter int INST_WIDTH    = 32,
  parameter int REG_WIDTH     = 32,
  parameter int IMM_SEL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_WIDTH-1:0]    inst,
  input  logic [IMM_SEL_WIDTH-1:0] imm_sel,
  input  logic [REG_WIDTH-1:0]     pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_WIDTH-1:0]     imm_out,
  output logic [REG_WIDTH-1:0]     tgt_out,
  output logic                     illegal
);
  typedef struct packed {
    logic                 illegal;
    logic [REG_WIDTH-1:0] imm;
    logic [REG_WIDTH-1:0] tgt;
  } entry_t;

  entry_t new_e, out_q, skid_q;
  logic   out_vld, skid_vld;
  logic   push, pop;

  imm_gen_dec #(.REG_WIDTH(REG_WIDTH), .IMM_SEL_WIDTH(IMM_SEL_WIDTH)) u_dec (
    .inst    (inst[31:0]),
    .sel     (imm_sel),
    .pc      (pc),
    .imm     (new_e.imm),
    .tgt     (new_e.tgt),
    .illegal (new_e.illegal)
  );

  // in_ready depends only on state, so there is no comb path from out_ready
  assign in_ready  = ~skid_vld;
  assign push      = in_valid & in_ready;
  assign pop       = out_vld & out_ready;
  assign out_valid = out_vld;
  assign imm_out   = out_q.imm;
  assign tgt_out   = out_q.tgt;
  assign illegal   = out_q.illegal;

  // Valid bits: flush wins; the skid only fills while the output is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (~out_vld | pop) begin
      // skid full implies in_ready=0, so skid refill and push never collide
      out_vld  <= skid_vld | push;
      skid_vld <= 1'b0;
    end else if (push) begin
      skid_vld <= 1'b1;
    end
  end

  // Data path: output reg loads from skid first (FIFO order), otherwise from the decoder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (~out_vld | pop) begin
        if (skid_vld)  out_q <= skid_q;
        else if (push) out_q <= new_e;
      end else if (push) begin
        skid_q <= new_e;
      end
    end
  end
endmodule
